moving_avg_stream_filter: RTL and testbench

Parametrised streaming successor to the fixed 51-tap array moving-average filter. It accepts one unsigned sample per valid/ready handshake and keeps a circular history buffer and a running sum. Each output is computed with a multicycle restoring divider, so TAPS need not be a power of two. It sits between the sample source and the output buffer in the filter datapath, and adds configurable warm-up behaviour, optional rounding, and a synchronous history clear.

---
 rtl/moving_avg_stream_filter.sv | 145 ++++++++++++++
 tb/tb_moving_avg_stream_filter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_avg_stream_filter.sv
// moving_avg_stream_filter: streaming moving average over the last TAPS
// unsigned samples. Keeps a circular history and a running sum, and divides
// by the number of held samples with a bit-serial restoring divider. One
// sample is in flight at a time: accept -> SUM_W divide cycles -> output.
module moving_avg_stream_filter #(
    parameter int DATA_W      = 8,
    parameter int TAPS        = 51,
    parameter int WARMUP_MODE = 0,
    parameter int ROUND       = 0,
    parameter int SUM_W       = DATA_W + $clog2(TAPS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              win_full
);
    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam int PTR_W  = $clog2(TAPS);
    localparam int ITER_W = $clog2(SUM_W);
    localparam logic [CNT_W-1:0]  TAPS_C    = CNT_W'(TAPS);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(TAPS - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(SUM_W - 1);

    typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] buf_q [TAPS];
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic              win_full_q;
    // Dividend shifts out of the top while quotient bits shift in at the bottom.
    logic [SUM_W-1:0]  dvd_q, dvd_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  dsr_q;
    logic [ITER_W-1:0] iter_q;
    logic              zero_q;
    logic [DATA_W-1:0] out_data_q;
    logic              accept, last_iter;
    logic [DATA_W-1:0] oldest;
    logic [CNT_W:0]    trial;
    logic [CNT_W-1:0]  diff;
    logic              ge;

    // Half-divisor bias that turns floor division into round-half-up.
    function automatic logic [SUM_W-1:0] round_bias(input logic [CNT_W-1:0] cnt);
        if (ROUND != 0) return SUM_W'(cnt >> 1);
        return '0;
    endfunction

    assign in_ready  = (state_q == IDLE) && !clear;
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign win_full  = win_full_q;
    assign accept    = in_valid && in_ready;
    assign last_iter = (state_q == DIV) && (iter_q == ITER_LAST);

    // Next-state logic; clear overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = DIV;
            DIV:     if (last_iter) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    // Window bookkeeping for the sample being accepted; the evicted entry only
    // counts once the window is full (earlier slots are still zero anyway).
    always_comb begin
        oldest = (cnt_q == TAPS_C) ? buf_q[wptr_q] : '0;
        sum_d  = sum_q + SUM_W'(in_data) - SUM_W'(oldest);
        cnt_d  = (cnt_q == TAPS_C) ? cnt_q : cnt_q + CNT_W'(1);
        wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
    end

    // One restoring division step; the remainder always stays below the divisor.
    always_comb begin
        trial = {rem_q, dvd_q[SUM_W-1]};
        ge    = (trial >= {1'b0, dsr_q});
        diff  = trial[CNT_W-1:0] - dsr_q;
        rem_d = ge ? diff : trial[CNT_W-1:0];
        dvd_d = {dvd_q[SUM_W-2:0], ge};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // History buffer, running sum, sample count and write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            win_full_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            win_full_q <= 1'b0;
        end else if (accept) begin
            buf_q[wptr_q] <= in_data;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            wptr_q        <= wptr_d;
            win_full_q    <= (cnt_d == TAPS_C);
        end
    end

    // Divider load on accept, iterate in DIV, register the result on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            iter_q     <= '0;
            zero_q     <= 1'b0;
            out_data_q <= '0;
        end else if (accept) begin
            dvd_q  <= sum_d + round_bias(cnt_d);
            rem_q  <= '0;
            dsr_q  <= cnt_d;
            iter_q <= '0;
            zero_q <= (WARMUP_MODE == 0) && (cnt_d != TAPS_C);
        end else if ((state_q == DIV) && !clear) begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            iter_q <= iter_q + ITER_W'(1);
            if (last_iter) out_data_q <= zero_q ? '0 : dvd_d[DATA_W-1:0];
        end
    end
endmodule

// File: tb/tb_moving_avg_stream_filter.sv
// Bench for moving_avg_stream_filter: four configurations side by side, a
// sliding-window reference model checked every cycle, plus literal vectors.
`timescale 1ns/1ps
module tb_moving_avg_stream_filter;
    localparam int NC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear     [NC];
    logic       in_valid  [NC];
    logic       in_ready  [NC];
    logic [7:0] in_data   [NC];
    logic       out_valid [NC];
    logic       out_ready [NC];
    logic [7:0] out_data  [NC];
    logic       win_full  [NC];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int win_q   [NC][$];
    int busy    [NC];
    int elapsed [NC];
    int expv    [NC];
    int p_acc   [NC];
    int p_clr   [NC];
    int p_xfer  [NC];
    int p_dat   [NC];

    always #5 clk = ~clk;

    moving_avg_stream_filter #(.DATA_W(8), .TAPS(51), .WARMUP_MODE(0), .ROUND(0)) u0 (
        .clk(clk), .rst(rst), .clear(clear[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .win_full(win_full[0]));
    moving_avg_stream_filter #(.DATA_W(8), .TAPS(51), .WARMUP_MODE(1), .ROUND(0)) u1 (
        .clk(clk), .rst(rst), .clear(clear[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .win_full(win_full[1]));
    moving_avg_stream_filter #(.DATA_W(8), .TAPS(51), .WARMUP_MODE(1), .ROUND(1)) u2 (
        .clk(clk), .rst(rst), .clear(clear[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .win_full(win_full[2]));
    moving_avg_stream_filter #(.DATA_W(8), .TAPS(4), .WARMUP_MODE(0), .ROUND(0)) u3 (
        .clk(clk), .rst(rst), .clear(clear[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_data(out_data[3]), .win_full(win_full[3]));

    function automatic int taps_of(input int c);
        return (c == 3) ? 4 : 51;
    endfunction
    function automatic int wm_of(input int c);
        return (c == 1 || c == 2) ? 1 : 0;
    endfunction
    function automatic int rnd_of(input int c);
        return (c == 2) ? 1 : 0;
    endfunction
    function automatic int sw_of(input int c);
        return 8 + $clog2(taps_of(c) + 1);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected average of the current window, straight from the definition.
    function automatic int model_avg(input int c);
        int s = 0;
        int n = win_q[c].size();
        for (int k = 0; k < n; k++) s += win_q[c][k];
        if (wm_of(c) == 0 && n < taps_of(c)) return 0;
        return (s + ((rnd_of(c) != 0) ? n / 2 : 0)) / n;
    endfunction

    // Per-cycle comparison against the model, evaluated on the falling edge.
    task automatic monitor();
        for (int c = 0; c < NC; c++) begin
            if (rst) begin
                win_q[c].delete();
                busy[c] = 0; elapsed[c] = 0; expv[c] = 0;
                p_acc[c] = 0; p_clr[c] = 0; p_xfer[c] = 0; p_dat[c] = 0;
                check($sformatf("c%0d reset out_valid", c), int'(out_valid[c]), 0);
                check($sformatf("c%0d reset in_ready", c), int'(in_ready[c]), 1);
                check($sformatf("c%0d reset win_full", c), int'(win_full[c]), 0);
                check($sformatf("c%0d reset out_data", c), int'(out_data[c]), 0);
            end else begin
                if (p_clr[c] != 0) begin
                    win_q[c].delete();
                    busy[c] = 0;
                end else begin
                    if (p_xfer[c] != 0) busy[c] = 0;
                    if (p_acc[c] != 0) begin
                        win_q[c].push_back(p_dat[c]);
                        if (win_q[c].size() > taps_of(c)) void'(win_q[c].pop_front());
                        expv[c] = model_avg(c);
                        busy[c] = 1;
                        elapsed[c] = 0;
                    end else if (busy[c] != 0) begin
                        elapsed[c]++;
                    end
                end
                begin
                    int ev;
                    ev = (busy[c] != 0 && elapsed[c] >= sw_of(c)) ? 1 : 0;
                    check($sformatf("c%0d out_valid", c), int'(out_valid[c]), ev);
                    check($sformatf("c%0d in_ready", c), int'(in_ready[c]),
                          (busy[c] == 0 && !clear[c]) ? 1 : 0);
                    check($sformatf("c%0d win_full", c), int'(win_full[c]),
                          (win_q[c].size() == taps_of(c)) ? 1 : 0);
                    if (ev != 0) check($sformatf("c%0d out_data", c), int'(out_data[c]), expv[c]);
                    p_acc[c]  = (in_valid[c] && busy[c] == 0 && !clear[c]) ? 1 : 0;
                    p_clr[c]  = clear[c] ? 1 : 0;
                    p_xfer[c] = (ev != 0 && out_ready[c]) ? 1 : 0;
                    p_dat[c]  = int'(in_data[c]);
                end
            end
        end
    endtask

    task automatic push(input int c, input int x);
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready[c] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready[c]) begin
            check($sformatf("c%0d in_ready timeout", c), 0, 1);
            return;
        end
        in_valid[c] = 1'b1;
        in_data[c]  = 8'(x);
        @(posedge clk); #1;
        in_valid[c] = 1'b0;
    endtask

    task automatic get(input int c, output int lat, output int val);
        lat = 0;
        while (!out_valid[c] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid[c]) check($sformatf("c%0d out_valid timeout", c), 0, 1);
        val = int'(out_data[c]);
    endtask

    task automatic send(input string nm, input int c, input int x, input int exp);
        int lat, v;
        push(c, x);
        get(c, lat, v);
        check({nm, " data"}, v, exp);
        check({nm, " latency"}, lat, sw_of(c));
    endtask

    task automatic pulse_clear(input int c);
        @(posedge clk); #1 clear[c] = 1'b1;
        @(posedge clk); #1 clear[c] = 1'b0;
    endtask

    initial begin
        int lat, v;
        int t3_in  [6] = '{4, 8, 12, 16, 20, 100};
        int t3_exp [6] = '{0, 0, 0, 10, 14, 37};
        rst = 1'b1;
        for (int c = 0; c < NC; c++) begin
            clear[c] = 1'b0; in_valid[c] = 1'b0; in_data[c] = '0; out_ready[c] = 1'b1;
        end
        fork
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Warm-up zeros, then full-window averages of 255
        for (int i = 1; i <= 60; i++) begin
            push(0, 255);
            get(0, lat, v);
            check($sformatf("t1 latency %0d", i), lat, 14);
            check($sformatf("t1 out %0d", i), v, (i <= 50) ? 0 : 255);
            check($sformatf("t1 win_full %0d", i), int'(win_full[0]), (i >= 51) ? 1 : 0);
        end

        // Partial averages, floor and round-half-up
        send("t2 floor 10", 1, 10, 10);
        send("t2 floor 20", 1, 20, 15);
        send("t2 floor 31", 1, 31, 20);
        send("t2 round 10", 2, 10, 10);
        send("t2 round 20", 2, 20, 15);
        send("t2 round 31", 2, 31, 20);
        pulse_clear(2);
        send("t2 round 1", 2, 1, 1);
        send("t2 round 2", 2, 2, 2);

        // Eviction and wrap on a 4-tap window, then random traffic
        for (int i = 0; i < 6; i++) send($sformatf("t3 vec %0d", i), 3, t3_in[i], t3_exp[i]);
        for (int i = 0; i < 300; i++) begin
            push(3, int'($urandom_range(0, 255)));
            get(3, lat, v);
        end

        // Backpressure: result holds, input blocked, stray in_valid ignored
        out_ready[0] = 1'b0;
        push(0, 0);
        get(0, lat, v);
        check("t4 stalled data", v, 250);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 10) begin in_valid[0] = 1'b1; in_data[0] = 8'd7; end
            if (k == 11) in_valid[0] = 1'b0;
            check($sformatf("t4 hold data %0d", k), int'(out_data[0]), 250);
            check($sformatf("t4 hold in_ready %0d", k), int'(in_ready[0]), 0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("t4 release out_valid", int'(out_valid[0]), 0);
        check("t4 release in_ready", int'(in_ready[0]), 1);
        send("t4 after release", 0, 255, 250);

        // Clear during a division discards it and all history
        send("t5 s4", 1, 40, 25);
        send("t5 s5", 1, 50, 30);
        push(1, 60);
        repeat (3) begin @(posedge clk); #1; end
        clear[1] = 1'b1;
        @(posedge clk); #1 clear[1] = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        check("t5 no out_valid", int'(out_valid[1]), 0);
        check("t5 win_full", int'(win_full[1]), 0);
        send("t5 nine a", 1, 9, 9);
        send("t5 nine b", 1, 9, 9);
        send("t5 nine c", 1, 9, 9);

        // Asynchronous reset while holding a result
        out_ready[0] = 1'b0;
        push(0, 255);
        get(0, lat, v);
        #1 rst = 1'b1;
        #1;
        check("t6 async out_valid", int'(out_valid[0]), 0);
        check("t6 async in_ready", int'(in_ready[0]), 1);
        check("t6 async out_data", int'(out_data[0]), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        out_ready[0] = 1'b1;
        send("t6 cold 1", 0, 255, 0);
        send("t6 cold 2", 0, 255, 0);
        check("t6 cold win_full", int'(win_full[0]), 0);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
